// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the multi-port register file.
//   wr_src_t  : identifies which write source won arbitration this cycle
//   REG_*     : architectural register indices used by decode/PC logic
//   be_merge  : byte-wise merge used by both the array write and the bypass
//               path, so both see exactly the same merge semantics
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_BUF  = 3'd1,
        SRC_ALU  = 3'd2,
        SRC_LD   = 3'd3,
        SRC_LINK = 3'd4
    } wr_src_t;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;
    localparam int REG_V0   = 2;

    // Widest data path the merge helper supports; callers zero-extend to
    // this width and truncate the result back to their own DW.
    localparam int MAX_DW   = 256;

    function automatic logic [MAX_DW-1:0] be_merge(
        input logic [MAX_DW-1:0]   old_v,
        input logic [MAX_DW-1:0]   new_v,
        input logic [MAX_DW/8-1:0] be
    );
        logic [MAX_DW-1:0] res;
        res = old_v;
        for (int i = 0; i < MAX_DW / 8; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_v[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_v[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bus between decode / ALU / load-store / PC and the register file.
//   rd_addr/rd_data : NRD packed read ports
//   alu_*, ld_*, link_* : three write sources (ld carries byte enables)
//   stall : deferred write buffer occupied
//   ovf   : sticky dropped-write flag
//   v0    : committed value of the observed register
// master = requester side, slave = register file.
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
);
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic              alu_we;
    logic [AW-1:0]     alu_addr;
    logic [DW-1:0]     alu_data;
    logic              ld_we;
    logic [AW-1:0]     ld_addr;
    logic [DW-1:0]     ld_data;
    logic [DW/8-1:0]   ld_be;
    logic              link_we;
    logic [AW-1:0]     link_addr;
    logic [DW-1:0]     link_data;
    logic              stall;
    logic              ovf;
    logic [DW-1:0]     v0;

    modport master (
        output rd_addr, alu_we, alu_addr, alu_data,
               ld_we, ld_addr, ld_data, ld_be,
               link_we, link_addr, link_data,
        input  rd_data, stall, ovf, v0
    );

    modport slave (
        input  rd_addr, alu_we, alu_addr, alu_data,
               ld_we, ld_addr, ld_data, ld_be,
               link_we, link_addr, link_data,
        output rd_data, stall, ovf, v0
    );
endinterface

// File: rtl/regfile_mp_wr_arb.sv
// -----------------------------------------------------------------------------
// regfile_wr_arb
// Fixed-priority write arbiter with a one-entry deferred write buffer.
// Priority: BUF > ALU > LD > LINK. The first loser is parked in the buffer,
// any further loser is dropped and raises the sticky ovf flag.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_alu_*, i_ld_*, i_link_* : write requests
//   o_win_*                : winner committed at the next rising edge
//   o_buf_*                : buffer contents (for read bypass)
//   o_stall, o_ovf         : registered status
// -----------------------------------------------------------------------------
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_alu_we,
    input  logic [AW-1:0]     i_alu_addr,
    input  logic [DW-1:0]     i_alu_data,
    input  logic              i_ld_we,
    input  logic [AW-1:0]     i_ld_addr,
    input  logic [DW-1:0]     i_ld_data,
    input  logic [DW/8-1:0]   i_ld_be,
    input  logic              i_link_we,
    input  logic [AW-1:0]     i_link_addr,
    input  logic [DW-1:0]     i_link_data,
    output logic              o_win_valid,
    output wr_src_t           o_win_src,
    output logic [AW-1:0]     o_win_addr,
    output logic [DW-1:0]     o_win_data,
    output logic [DW/8-1:0]   o_win_be,
    output logic              o_buf_valid,
    output logic [AW-1:0]     o_buf_addr,
    output logic [DW-1:0]     o_buf_data,
    output logic [DW/8-1:0]   o_buf_be,
    output logic              o_stall,
    output logic              o_ovf
);
    localparam int BW = DW / 8;

    logic            r_buf_valid;
    logic [AW-1:0]   r_buf_addr;
    logic [DW-1:0]   r_buf_data;
    logic [BW-1:0]   r_buf_be;
    logic            r_ovf;

    // Writes to r0 are consumed with no effect, so they never compete.
    logic w_alu_req, w_ld_req, w_link_req;
    assign w_alu_req  = i_alu_we  && (i_alu_addr  != AW'(REG_ZERO));
    assign w_ld_req   = i_ld_we   && (i_ld_addr   != AW'(REG_ZERO)) && (i_ld_be != '0);
    assign w_link_req = i_link_we && (i_link_addr != AW'(REG_ZERO));

    wr_src_t       w_first, w_second, w_third, w_win_src, w_fill_src;
    logic          w_drop;
    logic [AW-1:0] w_win_addr, w_fill_addr;
    logic [DW-1:0] w_win_data, w_fill_data;
    logic [BW-1:0] w_win_be, w_fill_be;

    // Rank new requests, pick winner, buffer candidate and drop condition.
    always_comb begin
        w_first  = SRC_NONE;
        w_second = SRC_NONE;
        w_third  = SRC_NONE;
        if (w_alu_req) begin
            w_first = SRC_ALU;
        end else begin
            w_first = SRC_NONE;
        end
        if (w_ld_req) begin
            if (w_first == SRC_NONE) begin
                w_first = SRC_LD;
            end else begin
                w_second = SRC_LD;
            end
        end else begin
            w_second = SRC_NONE;
        end
        if (w_link_req) begin
            if (w_first == SRC_NONE) begin
                w_first = SRC_LINK;
            end else if (w_second == SRC_NONE) begin
                w_second = SRC_LINK;
            end else begin
                w_third = SRC_LINK;
            end
        end else begin
            w_third = SRC_NONE;
        end
        // A valid buffer always wins, so it always drains this cycle and
        // can take the first new request as its next occupant.
        if (r_buf_valid) begin
            w_win_src  = SRC_BUF;
            w_fill_src = w_first;
            w_drop     = (w_second != SRC_NONE);
        end else begin
            w_win_src  = w_first;
            w_fill_src = w_second;
            w_drop     = (w_third != SRC_NONE);
        end
    end

    // Winner payload mux.
    always_comb begin
        case (w_win_src)
            SRC_BUF:  begin w_win_addr = r_buf_addr;  w_win_data = r_buf_data;  w_win_be = r_buf_be; end
            SRC_ALU:  begin w_win_addr = i_alu_addr;  w_win_data = i_alu_data;  w_win_be = '1;       end
            SRC_LD:   begin w_win_addr = i_ld_addr;   w_win_data = i_ld_data;   w_win_be = i_ld_be;  end
            SRC_LINK: begin w_win_addr = i_link_addr; w_win_data = i_link_data; w_win_be = '1;       end
            default:  begin w_win_addr = '0;          w_win_data = '0;          w_win_be = '0;       end
        endcase
    end

    // Buffer-fill payload mux (the buffer itself is never a fill source).
    always_comb begin
        case (w_fill_src)
            SRC_ALU:  begin w_fill_addr = i_alu_addr;  w_fill_data = i_alu_data;  w_fill_be = '1;      end
            SRC_LD:   begin w_fill_addr = i_ld_addr;   w_fill_data = i_ld_data;   w_fill_be = i_ld_be; end
            SRC_LINK: begin w_fill_addr = i_link_addr; w_fill_data = i_link_data; w_fill_be = '1;      end
            default:  begin w_fill_addr = '0;          w_fill_data = '0;          w_fill_be = '0;      end
        endcase
    end

    // Deferred buffer and sticky overflow flag; reset discards a pending entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_buf_be    <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_buf_valid <= (w_fill_src != SRC_NONE);
            r_buf_addr  <= w_fill_addr;
            r_buf_data  <= w_fill_data;
            r_buf_be    <= w_fill_be;
            r_ovf       <= r_ovf | w_drop;
        end
    end

    assign o_win_valid = (w_win_src != SRC_NONE);
    assign o_win_src   = w_win_src;
    assign o_win_addr  = w_win_addr;
    assign o_win_data  = w_win_data;
    assign o_win_be    = w_win_be;
    assign o_buf_valid = r_buf_valid;
    assign o_buf_addr  = r_buf_addr;
    assign o_buf_data  = r_buf_data;
    assign o_buf_be    = r_buf_be;
    assign o_stall     = r_buf_valid;
    assign o_ovf       = r_ovf;
endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-read-port register file with three arbitrated write sources and a
// one-entry deferred write buffer.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : regfile_mp_if.slave (read ports, write requests, stall/ovf/v0)
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW     = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int V0_IDX = REG_V0
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);
    localparam int BW = DW / 8;

    logic [DW-1:0]   r_regs [NREGS];

    logic            w_win_valid;
    wr_src_t         w_win_src;
    logic [AW-1:0]   w_win_addr;
    logic [DW-1:0]   w_win_data;
    logic [BW-1:0]   w_win_be;
    logic            w_buf_valid;
    logic [AW-1:0]   w_buf_addr;
    logic [DW-1:0]   w_buf_data;
    logic [BW-1:0]   w_buf_be;
    logic            w_win_in_range;

    regfile_wr_arb #(.DW(DW), .AW(AW)) u_arb (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_alu_we    (bus.alu_we),
        .i_alu_addr  (bus.alu_addr),
        .i_alu_data  (bus.alu_data),
        .i_ld_we     (bus.ld_we),
        .i_ld_addr   (bus.ld_addr),
        .i_ld_data   (bus.ld_data),
        .i_ld_be     (bus.ld_be),
        .i_link_we   (bus.link_we),
        .i_link_addr (bus.link_addr),
        .i_link_data (bus.link_data),
        .o_win_valid (w_win_valid),
        .o_win_src   (w_win_src),
        .o_win_addr  (w_win_addr),
        .o_win_data  (w_win_data),
        .o_win_be    (w_win_be),
        .o_buf_valid (w_buf_valid),
        .o_buf_addr  (w_buf_addr),
        .o_buf_data  (w_buf_data),
        .o_buf_be    (w_buf_be),
        .o_stall     (bus.stall),
        .o_ovf       (bus.ovf)
    );

    assign w_win_in_range = ({1'b0, w_win_addr} < (AW+1)'(NREGS));

    // Register array: cleared on reset, otherwise the winner's enabled bytes commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_win_valid && w_win_in_range) begin
            r_regs[w_win_addr] <= DW'(be_merge(MAX_DW'(r_regs[w_win_addr]),
                                               MAX_DW'(w_win_data),
                                               (MAX_DW/8)'(w_win_be)));
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_in_range;
        logic [DW-1:0] w_val;

        assign w_addr     = bus.rd_addr[k*AW +: AW];
        assign w_in_range = ({1'b0, w_addr} < (AW+1)'(NREGS));

        // Read port: array value, optionally overlaid with buffer then winner bytes.
        always_comb begin
            w_val = r_regs[w_addr];
            if (BYPASS != 0) begin
                if (w_buf_valid && (w_buf_addr == w_addr)) begin
                    w_val = DW'(be_merge(MAX_DW'(w_val), MAX_DW'(w_buf_data),
                                         (MAX_DW/8)'(w_buf_be)));
                end else begin
                    w_val = w_val;
                end
                if (w_win_valid && (w_win_src != SRC_BUF) && (w_win_addr == w_addr)) begin
                    w_val = DW'(be_merge(MAX_DW'(w_val), MAX_DW'(w_win_data),
                                         (MAX_DW/8)'(w_win_be)));
                end else begin
                    w_val = w_val;
                end
            end else begin
                w_val = w_val;
            end
            // r0 and out-of-range addresses read as zero regardless of contents.
            if ((w_addr == AW'(REG_ZERO)) || !w_in_range) begin
                w_val = '0;
            end else begin
                w_val = w_val;
            end
        end

        assign bus.rd_data[k*DW +: DW] = w_val;
    end

    assign bus.v0 = r_regs[V0_IDX];
endmodule
